shift_pack_fifo: RTL
====================

Name: shift_pack_fifo

Overview:
Downstream consumer of the down-counter's shift/wr control pair.
- While shift is high, serial bits on sin are shifted MSB-first into a word register.
- A wr pulse packs the assembled word and its bit count into a small FIFO.
- A valid/ready interface drains the FIFO to the next stage, e.g. a display or register file.

Parameters:
DATA_W, 8, width of assembled word and shift register
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 4, width of bit-count field (holds 0..DATA_W)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
shift  in  1  shift enable from down-counter; sin sampled when high
wr  in  1  single-cycle write strobe from down-counter; pushes current word
sin  in  1  serial data bit
out_ready  in  1  downstream accepts head entry
clr_ovf  in  1  synchronous clear of overflow flag
out_valid  out  1  FIFO non-empty
out_data  out  DATA_W  head-entry word
out_nbits  out  CNT_W  head-entry number of valid bits (LSB-aligned)
level  out  clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On reset:
  - shift register = 0, bit count = 0
  - FIFO pointers = 0, level = 0
  - out_valid = 0, out_data = 0, out_nbits = 0, overflow = 0
- Shift: shift=1 -> sreg <= {sreg[DATA_W-2:0], sin}.
  - nbits increments and saturates at DATA_W.
  - Bits beyond DATA_W push out the oldest bits; no error is raised.
- Next word: nword = shift ? {sreg[DATA_W-2:0], sin} : sreg. nnb is the matching next bit count.
- Push on wr=1: {nword, nnb} is written to FIFO.
  - In the same cycle, sreg and nbits clear to 0.
  - wr with nbits=0 and shift=0 pushes {0, 0}; this is legal and is not filtered.
- Pop: out_valid & out_ready -> read pointer advances at the clock edge. out_data and out_nbits show the new head in the following cycle.
- Outputs are driven combinationally from the head entry, with no extra read latency. Push-to-out_valid latency is 1 cycle: wr at edge N gives out_valid at N+1.
- Full (level=DEPTH):
  - Push with a simultaneous pop is accepted, and level is unchanged.
  - Push without a pop is dropped, and overflow <= 1.
- Empty: out_valid=0, out_data and out_nbits hold their last values, and out_ready is ignored. A simultaneous push and pop on empty is a push only, because no pop is valid.
- overflow stays set until clr_ovf=1.
  - If clr_ovf and a drop occur in the same cycle, set wins.
- Pointers are CLOG2(DEPTH) bits wide and wrap modulo DEPTH. level is tracked separately and ranges 0..DEPTH.
- Reset mid-operation clears everything immediately. Partial words and queued entries are lost.
- No state machine beyond the FIFO occupancy. All state updates are synchronous to clk except reset.

Decomposition:
- Package shift_pack_pkg holds:
  - localparams DATA_W, DEPTH, CNT_W
  - typedef struct packed {logic [CNT_W-1:0] nbits; logic [DATA_W-1:0] data;} entry_t
- Sub-module sync_fifo (parameterised on entry_t and DEPTH) contains the storage, pointers, level and full/empty logic. It exposes push, pop, din, dout, full, empty and level.
- The top level holds the shift register, the bit counter and the overflow flag.

Test Plan:
- Reset, then shift=1 for 3 cycles with sin=1,0,1 and wr on the 3rd cycle -> next cycle out_valid=1, out_data=8'h05, out_nbits=3, level=1.
- Shift 10 bits 1,1,0,0,1,0,1,0,1,1 with wr on the last bit -> out_data=8'h2B (last 8 bits), out_nbits=8.
- 4 pushes with out_ready=0 -> level=4. 5th push -> dropped, overflow=1, level=4. Pop all 4 -> first-in-first-out order preserved. clr_ovf -> overflow=0.
- Full FIFO, push and pop in the same cycle -> level stays 4, new entry appears last, overflow stays 0.
- Assert rst asynchronously mid-shift with 2 entries queued -> out_valid=0, level=0 and overflow=0 immediately, before the next clk edge.
- wr with no prior shift -> entry {data=0, nbits=0} pushed. 8 alternating push/pop cycles -> pointers wrap, data is correct and level ends at 0.

Source files
------------

// File: rtl/shift_pack_pkg.sv
// Shared widths and the FIFO entry payload for the serial shift/pack path.
package shift_pack_pkg;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   typedef struct packed {
      logic [CNT_W-1:0]  nbits;
      logic [DATA_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head entry; the head holds its last value when empty.
module sync_fifo #(
   parameter type         entry_t = logic [7:0],
   parameter int unsigned DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  entry_t                 din,
   output entry_t                 dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   rptr;
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr_n;
   logic [LVL_W-1:0]   level_n;
   logic               pop_ok;
   logic               push_ok;
   entry_t             head_n;

   assign empty = (level == '0);
   assign full  = (level == LVL_W'(DEPTH));

   // A push into the slot that becomes the head bypasses storage.
   always_comb begin
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      rptr_n  = rptr + PTR_W'(pop_ok);
      level_n = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
      head_n  = dout;
      if (level_n != '0) begin
         head_n = (push_ok && (wptr == rptr_n)) ? din : mem[rptr_n];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr  <= '0;
         wptr  <= '0;
         level <= '0;
         dout  <= '0;
      end else begin
         rptr  <= rptr_n;
         level <= level_n;
         dout  <= head_n;
         if (push_ok) begin
            wptr <= wptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr] <= din;
      end
   end
endmodule

// File: rtl/shift_pack_fifo.sv
// Assembles MSB-first serial bits into words and queues {word, bit count} for a valid/ready consumer.
module shift_pack_fifo
   import shift_pack_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic             wr,
   input  logic             sin,
   input  logic             out_ready,
   input  logic             clr_ovf,
   output logic             out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0] out_nbits,
   output logic [LVL_W-1:0] level,
   output logic             overflow
);
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] nword;
   logic [CNT_W-1:0]  nbits;
   logic [CNT_W-1:0]  nnb;
   logic              full;
   logic              empty;
   logic              drop;
   entry_t            din;
   entry_t            dout;

   // Word/count as they would be after this cycle's shift; this is what wr packs.
   always_comb begin
      nword = shift ? {sreg[DATA_W-2:0], sin} : sreg;
      nnb   = nbits;
      if (shift && (nbits != CNT_W'(DATA_W))) begin
         nnb = nbits + CNT_W'(1);
      end
      din.data  = nword;
      din.nbits = nnb;
      drop      = wr & full & ~out_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg     <= '0;
         nbits    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            sreg  <= '0;
            nbits <= '0;
         end else begin
            sreg  <= nword;
            nbits <= nnb;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr),
      .pop   (out_ready),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign out_valid = ~empty;
   assign out_data  = dout.data;
   assign out_nbits = dout.nbits;
endmodule
